// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_ctrl (with helper key_generation)
// Purpose  : AES-128 key-expansion controller. Accepts a 128-bit cipher key,
//            expands it into 11 round keys at one round per clock, and holds
//            them in a register file for combinational read-back.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous active-low reset
//            key_valid  - cipher key offered on key_in
//            key_in     - AES-128 cipher key, w0 in [127:96]
//            key_ready  - block can accept a key this cycle
//            busy       - expansion in progress
//            done       - one-cycle pulse once rk[10] is stored
//            rk_valid   - bit i set when round key i is stored
//            rk_idx     - round-key read index 0..10
//            rk_out     - rk[rk_idx], or zero for rk_idx >= 11
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// key_generation: one AES-128 key-expansion round.
//   key      - previous round key
//   rc       - round counter 0..9, selects the round constant
//   next_key - following round key
// ----------------------------------------------------------------------------
module key_generation (
  input  logic [127:0] key,
  input  logic [3:0]   rc,
  output logic [127:0] next_key
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255 - x) * 8, and 255 - x == ~x for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] temp_word;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot_word  = {w3[23:0], w3[31:24]};
  assign sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                      sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
  assign temp_word = sub_word ^ {rcon(rc), 24'h000000};

  // Each new word chains off the one before it.
  assign n0 = w0 ^ temp_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// ----------------------------------------------------------------------------
// key_schedule_ctrl: top level controller and round-key register file.
// ----------------------------------------------------------------------------
module key_schedule_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic [10:0]  rk_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t       state;
  logic [3:0]   r;
  logic [127:0] rk [0:10];
  logic [127:0] prev_key;
  logic [127:0] kg_out;

  // Key input of the expansion stage is the most recently stored round key.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (r == 4'(i)) prev_key = rk[i];
    end
  end

  key_generation u_key_generation (
    .key      (prev_key),
    .rc       (r),
    .next_key (kg_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= 4'd0;
      rk_valid  <= 11'h000;
      done      <= 1'b0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            rk[0]     <= key_in;
            rk_valid  <= 11'h001;   // also drops stale rounds 1..10
            r         <= 4'd0;
            state     <= EXPAND;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i - 1)) begin
              rk[i]       <= kg_out;
              rk_valid[i] <= 1'b1;
            end
          end
          if (r == 4'd9) begin
            // Last round written: back to IDLE so a key offered during the
            // done cycle is taken immediately.
            r         <= 4'd0;
            state     <= IDLE;
            done      <= 1'b1;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r <= r + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read; indices 11..15 read as zero.
  always_comb begin
    rk_out = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rk_idx == 4'(i)) rk_out = rk[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_ctrl
// Purpose  : Scoreboard bench for key_schedule_ctrl. The stimulus thread
//            pushes the expected rk_valid progression (with round-key values
//            where known) and expected done cycles; the monitor thread pops
//            and compares whenever rk_valid changes or done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_OTHER = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_ZERO = 128'h62636363626363636263636362636363;

  typedef struct {
    logic [10:0]  valid;
    logic [3:0]   idx;
    logic [127:0] val;
    bit           chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [10:0]  rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic         stim_sel;
  logic [3:0]   stim_idx;
  logic [3:0]   mon_idx;
  logic         mon_en;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  exp_t exp_q[$];
  int   done_q[$];

  assign rk_idx = stim_sel ? stim_idx : mon_idx;

  key_schedule_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .rk_valid  (rk_valid),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [3:0] i, input logic [127:0] exp, input string name);
    stim_sel = 1'b1;
    stim_idx = i;
    #1;
    check(name, rk_out, exp);
    stim_sel = 1'b0;
  endtask

  task automatic push(input logic [10:0] v, input logic [3:0] i,
                      input logic [127:0] val, input bit c);
    exp_t e;
    e.valid = v;
    e.idx   = i;
    e.val   = val;
    e.chk   = c;
    exp_q.push_back(e);
  endtask

  // Full expansion: acceptance, rounds 1..10.
  task automatic push_run(input logic [127:0] key, input logic [127:0] rk1,
                          input logic [127:0] rk10, input bit chk10);
    push(11'h001, 4'd0, key, 1'b1);
    push(11'h003, 4'd1, rk1, 1'b1);
    for (int k = 2; k <= 9; k++)
      push(11'((1 << (k + 1)) - 1), 4'(k), '0, 1'b0);
    push(11'h7ff, 4'd10, rk10, chk10);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    stim_sel  = 1'b0;
    stim_idx  = 4'd0;
    mon_idx   = 4'd0;
    mon_en    = 1'b0;

    fork
      begin : stimulus
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        mon_en = 1'b1;

        // Reset state
        check("reset_key_ready", 128'(key_ready), 128'd1);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_rk_valid", 128'(rk_valid), 128'd0);
        for (int i = 0; i < 16; i++) rd(4'(i), '0, "reset_rk_out");

        // Run A: FIPS-197 key, with a rejected key offered at T+3
        push_run(KEY_FIPS, RK1_FIPS, RK10_FIPS, 1'b1);
        done_q.push_back(cyc + 11);
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        tick;
        key_valid = 1'b0;
        tick;
        tick;
        check("busy_key_ready", 128'(key_ready), 128'd0);
        key_valid = 1'b1;
        key_in    = KEY_OTHER;
        tick;
        key_valid = 1'b0;
        key_in    = '0;
        repeat (9) tick;

        // Read boundaries
        rd(4'd0, KEY_FIPS, "rd_idx0");
        rd(4'd10, RK10_FIPS, "rd_idx10");
        rd(4'd11, '0, "rd_idx11");
        rd(4'd15, '0, "rd_idx15");

        // Run B: FIPS key, then an all-zero key offered in the done cycle
        tick;
        push_run(KEY_FIPS, RK1_FIPS, RK10_FIPS, 1'b1);
        done_q.push_back(cyc + 11);
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        tick;
        key_valid = 1'b0;
        repeat (10) tick;
        check("done_cycle_key_ready", 128'(key_ready), 128'd1);
        push_run('0, RK1_ZERO, '0, 1'b0);
        done_q.push_back(cyc + 11);
        key_valid = 1'b1;
        key_in    = '0;
        tick;
        key_valid = 1'b0;
        repeat (12) tick;

        // Run C: reset sampled at T+5 aborts the expansion
        push(11'h001, 4'd0, KEY_FIPS, 1'b1);
        push(11'h003, 4'd1, RK1_FIPS, 1'b1);
        for (int k = 2; k <= 4; k++)
          push(11'((1 << (k + 1)) - 1), 4'(k), '0, 1'b0);
        push(11'h000, 4'd0, '0, 1'b1);
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        tick;
        key_valid = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        check("abort_key_ready", 128'(key_ready), 128'd1);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_rk_valid", 128'(rk_valid), 128'd0);
        for (int i = 0; i < 16; i++) rd(4'(i), '0, "abort_rk_out");
        repeat (15) tick;

        check("events_left", 128'(exp_q.size()), 128'd0);
        check("done_left", 128'(done_q.size()), 128'd0);
      end

      begin : monitor
        logic [10:0] prev_valid;
        logic        exp_busy;
        exp_t        e;
        int          d;
        prev_valid = 11'h000;
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (done === 1'b1) begin
              if (done_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 at cycle %0d, required no pulse", cyc);
              end else begin
                d = done_q.pop_front();
                check("done_cycle", 128'(cyc), 128'(d));
              end
            end
            if (rk_valid !== prev_valid) begin
              if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rk_valid_unexpected: got %h, required %h", rk_valid, prev_valid);
              end else begin
                e = exp_q.pop_front();
                check("rk_valid", 128'(rk_valid), 128'(e.valid));
                exp_busy = !(e.valid == 11'h7ff || e.valid == 11'h000);
                check("busy", 128'(busy), 128'(exp_busy));
                check("key_ready", 128'(key_ready), 128'(!exp_busy));
                if (e.chk) begin
                  mon_idx = e.idx;
                  #1;
                  check("rk_out", rk_out, e.val);
                end
              end
              prev_valid = rk_valid;
            end
          end
        end
      end
    join_any
    disable fork;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
